// File: rtl/inst_loader.sv
// -----------------------------------------------------------------------------
// inst_loader
//
// Serial instruction loader. A load session is opened with a one-cycle
// i_start pulse. Program bytes then arrive over a valid/ready handshake, two
// bytes per 16-bit instruction (high byte first). Each assembled instruction
// is written to instruction memory at BASE_ADDR + o_count (wrapping modulo
// 4096). The CPU is held through o_stop for the whole session. A session ends
// on i_end, or when MAX_WORDS instructions have been written (which is
// flagged as an error), with a one-cycle o_done pulse.
//
// Parameters
//   BASE_ADDR     first instruction-memory address written in a session
//   MAX_WORDS     instructions accepted per session before forced stop (1..4096)
//
// Ports
//   i_clk         clock, all state updates on the rising edge
//   i_reset       synchronous active-high reset
//   i_start       one-cycle session open request (honoured only when idle)
//   i_byte_valid  i_byte carries a program byte
//   i_byte        program byte (first = word[15:8], second = word[7:0])
//   i_end         one-cycle end-of-program marker
//   o_byte_ready  loader accepts i_byte this cycle
//   o_mem_we      instruction-memory write strobe
//   o_mem_addr    instruction-memory write address
//   o_mem_data    instruction word being written
//   o_stop        CPU hold, high for the whole session including DONE
//   o_count       instructions written in the current/last session
//   o_done        one-cycle session-complete pulse
//   o_error       sticky error flag for the current/last session
// -----------------------------------------------------------------------------
module inst_loader #(
  parameter logic [11:0] BASE_ADDR = 12'h000,
  parameter int          MAX_WORDS = 4096
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_start,
  input  logic        i_byte_valid,
  input  logic [7:0]  i_byte,
  input  logic        i_end,
  output logic        o_byte_ready,
  output logic        o_mem_we,
  output logic [11:0] o_mem_addr,
  output logic [15:0] o_mem_data,
  output logic        o_stop,
  output logic [11:0] o_count,
  output logic        o_done,
  output logic        o_error
);

  typedef enum logic [2:0] {
    IDLE,
    HI,
    LO,
    WRITE,
    DONE
  } state_t;

  // The limit is compared against a 13-bit incremented count so that
  // MAX_WORDS = 4096 is reachable even though o_count is only 12 bits wide.
  localparam logic [12:0] MAX_W = 13'(MAX_WORDS);

  state_t      state;
  state_t      state_next;
  logic [15:0] word;
  logic [11:0] count;
  logic        error;

  logic [12:0] count_inc;
  logic        at_max;
  logic        transfer;

  assign count_inc = {1'b0, count} + 13'd1;
  assign at_max    = (count_inc == MAX_W);

  // i_end takes priority over a coincident byte: ready drops combinationally,
  // so no transfer can happen on the cycle the session is being closed.
  assign o_byte_ready = ((state == HI) || (state == LO)) && !i_end;
  assign transfer     = i_byte_valid && o_byte_ready;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: state_next is defaulted before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (i_start) state_next = HI;
      end
      HI: begin
        if (i_end)         state_next = DONE;
        else if (transfer) state_next = LO;
      end
      LO: begin
        if (i_end)         state_next = DONE;
        else if (transfer) state_next = WRITE;
      end
      WRITE: begin
        state_next = at_max ? DONE : HI;
      end
      DONE: begin
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath: word assembly, instruction count and sticky error
  // ---------------------------------------------------------------------------
  // NOTE: the word register is a plain flop register (not a memory array), so
  // it is reset along with the control state; a reset mid-session therefore
  // leaves no stale half-instruction behind.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      word  <= 16'h0000;
      count <= 12'h000;
      error <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          // Count and error from the last session stay visible until the
          // next session is actually opened.
          if (i_start) begin
            count <= 12'h000;
            error <= 1'b0;
          end
        end
        HI: begin
          if (transfer) word[15:8] <= i_byte;
        end
        LO: begin
          // Ending with only the high byte received is a truncated program;
          // the partial byte is simply never written.
          if (i_end)         error     <= 1'b1;
          else if (transfer) word[7:0] <= i_byte;
        end
        WRITE: begin
          // Saturate at 4095 when the 4096th instruction is written.
          count <= count_inc[12] ? 12'hFFF : count_inc[11:0];
          if (at_max) error <= 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  // 12-bit addition wraps past 12'hFFF naturally.
  assign o_mem_we   = (state == WRITE);
  assign o_mem_addr = BASE_ADDR + count;
  assign o_mem_data = word;
  assign o_stop     = (state != IDLE);
  assign o_done     = (state == DONE);
  assign o_count    = count;
  assign o_error    = error;

endmodule
